// File: rtl/sample_deserializer.sv
// sample_deserializer
//   Serial-to-parallel converter for the FIR sample input path. Beats of
//   LANES bits are assembled into LENGTH-bit words, LSB-first or MSB-first.
//   Each finished word is presented on a single-entry valid/ready output slot.
//   The block also reports start-of-word resynchronisation (framing error)
//   and words dropped because the slot was full (overrun).
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          input enable; beats are ignored while low
//   i_din_valid   iv_din carries a beat
//   i_sof         marks a valid beat as beat 0 of a new word
//   iv_din        beat data (LANES bits)
//   ov_dout       completed word, held while o_dout_valid is high
//   o_dout_valid  word available
//   i_dout_ready  consumer accepts the word
//   o_overrun     one-cycle pulse: a completed word was dropped
//   o_frame_err   one-cycle pulse: i_sof arrived mid-word
module sample_deserializer #(
    parameter int unsigned LENGTH    = 24,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din_valid,
    input  logic              i_sof,
    input  logic [LANES-1:0]  iv_din,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_overrun,
    output logic              o_frame_err
);

    localparam int unsigned BEATS = LENGTH / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     beat_idx;
    logic [LENGTH-1:0] asm_q, asm_d;
    logic [LENGTH-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              ferr_q, ferr_d;
    logic              accept;
    logic              complete;
    logic              slot_free;

    always_comb begin
        accept    = i_en && i_din_valid;
        // A sof beat always restarts the word at beat 0, whatever cnt was.
        beat_idx  = i_sof ? '0 : cnt_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        ferr_d    = 1'b0;

        if (accept) begin
            // Constant-bound loop keeps every part-select static.
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_idx == CW'(k)) begin
                    if (MSB_FIRST) begin
                        asm_d[LENGTH - LANES - k*LANES +: LANES] = iv_din;
                    end else begin
                        asm_d[k*LANES +: LANES] = iv_din;
                    end
                end
            end
            complete = (beat_idx == LAST_BEAT);
            cnt_d    = complete ? '0 : beat_idx + CW'(1);
            ferr_d   = i_sof && (cnt_q != '0);
        end

        // Slot can take a new word if empty or being drained on this edge.
        slot_free = !valid_q || i_dout_ready;
        dout_d    = dout_q;
        valid_d   = valid_q && !i_dout_ready;
        overrun_d = complete && !slot_free;
        if (complete && slot_free) begin
            // asm_d already holds the final beat of the word.
            dout_d  = asm_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign ov_dout      = dout_q;
    assign o_dout_valid = valid_q;
    assign o_overrun    = overrun_q;
    assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_sample_deserializer.sv
// Testbench for sample_deserializer: 24-bit/1-lane LSB-first instance plus
// 24-bit/4-lane MSB-first and LSB-first instances fed the same beats.
module tb_sample_deserializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: LENGTH=24, LANES=1, LSB-first
    logic        a_en, a_valid, a_sof, a_rdy;
    logic [0:0]  a_din;
    logic [23:0] a_dout;
    logic        a_dv, a_ovr, a_ferr;

    // DUT B (MSB-first) and C (LSB-first): LENGTH=24, LANES=4
    logic        bc_en, bc_valid, bc_sof, bc_rdy;
    logic [3:0]  bc_din;
    logic [23:0] b_dout, c_dout;
    logic        b_dv, b_ovr, b_ferr, c_dv, c_ovr, c_ferr;

    sample_deserializer #(.LENGTH(24), .LANES(1), .MSB_FIRST(1'b0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(a_en), .i_din_valid(a_valid),
        .i_sof(a_sof), .iv_din(a_din), .ov_dout(a_dout), .o_dout_valid(a_dv),
        .i_dout_ready(a_rdy), .o_overrun(a_ovr), .o_frame_err(a_ferr)
    );

    sample_deserializer #(.LENGTH(24), .LANES(4), .MSB_FIRST(1'b1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(bc_en), .i_din_valid(bc_valid),
        .i_sof(bc_sof), .iv_din(bc_din), .ov_dout(b_dout), .o_dout_valid(b_dv),
        .i_dout_ready(bc_rdy), .o_overrun(b_ovr), .o_frame_err(b_ferr)
    );

    sample_deserializer #(.LENGTH(24), .LANES(4), .MSB_FIRST(1'b0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_en(bc_en), .i_din_valid(bc_valid),
        .i_sof(bc_sof), .iv_din(bc_din), .ov_dout(c_dout), .o_dout_valid(c_dv),
        .i_dout_ready(bc_rdy), .o_overrun(c_ovr), .o_frame_err(c_ferr)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [23:0] qc[$];
    int a_ovr_seen = 0;
    int a_ferr_seen = 0;
    int bc_flag_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare against the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_dv && a_rdy) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got 0x%0h expected no word at %0t", a_dout, $time);
                end else begin
                    check("a_word", 32'(a_dout), 32'(qa.pop_front()));
                end
            end
            if (a_ovr)  a_ovr_seen++;
            if (a_ferr) a_ferr_seen++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_dv && bc_rdy) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got 0x%0h expected no word at %0t", b_dout, $time);
                end else begin
                    check("b_word", 32'(b_dout), 32'(qb.pop_front()));
                end
            end
            if (c_dv && bc_rdy) begin
                if (qc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c_unexpected: got 0x%0h expected no word at %0t", c_dout, $time);
                end else begin
                    check("c_word", 32'(c_dout), 32'(qc.pop_front()));
                end
            end
            if (b_ovr || b_ferr || c_ovr || c_ferr) bc_flag_seen++;
        end
    end

    // Serialise one 24-bit word LSB-first into DUT A.
    // gap_at/gap_len: hold i_en low for gap_len cycles before beat gap_at.
    // rdy_at: raise a_rdy just before that beat (-1 = leave alone).
    task automatic send_a(input logic [23:0] w, input int gap_at, input int gap_len,
                          input bit chk_pre, input int rdy_at, input bit exp_ferr);
        for (int b = 0; b < 24; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    a_en = 1'b0; a_valid = 1'b1; a_sof = 1'b0; a_din = w[b];
                    @(posedge clk); #1;
                end
            end
            if (b == rdy_at) a_rdy = 1'b1;
            if (b == 23 && chk_pre) check("a_valid_before_last", 32'(a_dv), 32'd0);
            a_en = 1'b1; a_valid = 1'b1; a_sof = (b == 0); a_din = w[b];
            @(posedge clk); #1;
            if (b == 0) check("a_frame_err_beat0", 32'(a_ferr), 32'(exp_ferr));
        end
        a_en = 1'b0; a_valid = 1'b0; a_sof = 1'b0;
    endtask

    task automatic send_partial(input logic [23:0] w, input int n);
        for (int b = 0; b < n; b++) begin
            a_en = 1'b1; a_valid = 1'b1; a_sof = (b == 0); a_din = w[b];
            @(posedge clk); #1;
        end
        a_en = 1'b0; a_valid = 1'b0; a_sof = 1'b0;
    endtask

    logic [23:0] w;

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_valid = 1'b0; a_sof = 1'b0; a_din = '0; a_rdy = 1'b1;
        bc_en = 1'b0; bc_valid = 1'b0; bc_sof = 1'b0; bc_din = '0; bc_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_a_valid", 32'(a_dv), 32'd0);
        check("rst_a_overrun", 32'(a_ovr), 32'd0);
        check("rst_a_frame_err", 32'(a_ferr), 32'd0);
        check("rst_b_valid", 32'(b_dv), 32'd0);
        check("rst_c_dout", 32'(c_dout), 32'd0);
        rst = 1'b0;

        // Basic word, one-cycle valid with ready high
        qa.push_back(24'hA5C3F0);
        send_a(24'hA5C3F0, -1, 0, 1'b1, -1, 1'b0);
        check("a_latency_valid", 32'(a_dv), 32'd1);
        @(posedge clk); #1;
        check("a_valid_one_cycle", 32'(a_dv), 32'd0);

        // Random words, back-to-back
        for (int i = 0; i < 100; i++) begin
            w = 24'($urandom());
            qa.push_back(w);
            send_a(w, -1, 0, 1'b1, -1, 1'b0);
        end
        @(posedge clk); #1;

        // 4-lane instances
        qb.push_back(24'h123456);
        qc.push_back(24'h654321);
        for (int k = 0; k < 6; k++) begin
            bc_en = 1'b1; bc_valid = 1'b1; bc_sof = (k == 0); bc_din = 4'(k + 1);
            @(posedge clk); #1;
        end
        bc_en = 1'b0; bc_valid = 1'b0; bc_sof = 1'b0;
        check("b_latency_valid", 32'(b_dv), 32'd1);
        check("c_latency_valid", 32'(c_dv), 32'd1);
        @(posedge clk); #1;

        // i_en gap of 5 cycles mid-word
        qa.push_back(24'h5A963C);
        send_a(24'h5A963C, 10, 5, 1'b1, -1, 1'b0);
        check("gap_valid", 32'(a_dv), 32'd1);
        @(posedge clk); #1;

        // Overrun: slot stays full, second word dropped
        a_rdy = 1'b0;
        qa.push_back(24'h111111);
        send_a(24'h111111, -1, 0, 1'b1, -1, 1'b0);
        check("ovr_first_valid", 32'(a_dv), 32'd1);
        check("ovr_first_dout", 32'(a_dout), 32'h111111);
        send_a(24'h222222, -1, 0, 1'b0, -1, 1'b0);
        check("ovr_pulse", 32'(a_ovr), 32'd1);
        check("ovr_dout_kept", 32'(a_dout), 32'h111111);
        @(posedge clk); #1;
        check("ovr_pulse_end", 32'(a_ovr), 32'd0);
        a_rdy = 1'b1;
        @(posedge clk); #1;
        check("ovr_drained_valid", 32'(a_dv), 32'd0);
        check("ovr_drained_dout", 32'(a_dout), 32'h111111);

        // Transfer and completion on the same edge
        a_rdy = 1'b0;
        qa.push_back(24'hABCDEF);
        send_a(24'hABCDEF, -1, 0, 1'b1, -1, 1'b0);
        qa.push_back(24'h13579B);
        send_a(24'h13579B, -1, 0, 1'b0, 23, 1'b0);
        check("simul_valid", 32'(a_dv), 32'd1);
        check("simul_dout", 32'(a_dout), 32'h13579B);
        check("simul_no_ovr", 32'(a_ovr), 32'd0);
        @(posedge clk); #1;
        check("simul_drained", 32'(a_dv), 32'd0);

        // sof at beat 10 of a word: frame error, then clean word
        send_partial(24'hFFFFFF, 10);
        qa.push_back(24'h2468AC);
        send_a(24'h2468AC, -1, 0, 1'b1, -1, 1'b1);
        check("resync_valid", 32'(a_dv), 32'd1);
        @(posedge clk); #1;
        check("resync_ferr_clear", 32'(a_ferr), 32'd0);

        // Reset at beat 12, then clean word
        send_partial(24'h0F0F0F, 12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_dout", 32'(a_dout), 32'd0);
        check("midrst_valid", 32'(a_dv), 32'd0);
        check("midrst_overrun", 32'(a_ovr), 32'd0);
        check("midrst_frame_err", 32'(a_ferr), 32'd0);
        qa.push_back(24'h9E3779);
        send_a(24'h9E3779, -1, 0, 1'b1, -1, 1'b0);
        check("postrst_valid", 32'(a_dv), 32'd1);

        repeat (5) @(posedge clk);
        #1;
        check("qa_empty", 32'(qa.size()), 32'd0);
        check("qb_empty", 32'(qb.size()), 32'd0);
        check("qc_empty", 32'(qc.size()), 32'd0);
        check("a_overrun_count", 32'(a_ovr_seen), 32'd1);
        check("a_frame_err_count", 32'(a_ferr_seen), 32'd1);
        check("bc_flag_count", 32'(bc_flag_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
